// File: rtl/wbh_reg_gen_pkg.sv
// Shared definitions for the wishbone host configuration register bank.
package wbh_reg_gen_pkg;

  localparam logic [2:0] REG_GLB      = 3'd0;
  localparam logic [2:0] REG_BANK     = 3'd1;
  localparam logic [2:0] REG_SKEW_LO  = 3'd2;
  localparam logic [2:0] REG_SKEW_HI  = 3'd3;
  localparam logic [2:0] REG_LOCK     = 3'd4;
  localparam logic [2:0] REG_SOFT_RST = 3'd5;
  localparam logic [2:0] REG_RST_PW   = 3'd6;
  localparam logic [2:0] REG_STRAP    = 3'd7;

  // Pulse width loaded into RST_PW by the hardware reset.
  localparam int RST_PW_DEFAULT = 16;

  typedef enum logic {RP_IDLE = 1'b0, RP_ACTIVE = 1'b1} rp_state_e;

  // Strap code to skew adjustment: {0, +2, +4, -4}, applied modulo 16.
  function automatic logic [3:0] skew_delta(input logic [1:0] code);
    logic [3:0] d;
    case (code)
      2'b00:   d = 4'h0;
      2'b01:   d = 4'h2;
      2'b10:   d = 4'h4;
      default: d = 4'hC;
    endcase
    return d;
  endfunction

  // Replace the bytes of cur selected by be with the matching bytes of wd.
  function automatic logic [31:0] be_merge(input logic [31:0] cur, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? wd[8*b +: 8] : cur[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wbh_rst_pulse.sv
// One software reset channel: an active-low pulse of programmable width.
module wbh_rst_pulse #(
  parameter int PW_W = 8
) (
  input  logic            mclk,
  input  logic            p_reset_n,
  input  logic            trig,
  input  logic [PW_W-1:0] pw,
  output logic            rst_n,
  output logic            busy
);
  import wbh_reg_gen_pkg::*;

  rp_state_e       state;
  logic [PW_W-1:0] cnt;

  // Trigger (or re-trigger) loads the width, then count down to the release edge.
  always_ff @(posedge mclk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state <= RP_IDLE;
      cnt   <= '0;
    end else if (trig) begin
      state <= RP_ACTIVE;
      cnt   <= (pw == '0) ? PW_W'(1) : pw;
    end else if (state == RP_ACTIVE) begin
      cnt <= cnt - 1'b1;
      if (cnt == PW_W'(1)) state <= RP_IDLE;
    end
  end

  // Output decoded straight from state so the async reset releases it at once.
  assign busy  = (state == RP_ACTIVE);
  assign rst_n = ~busy;

endmodule

// File: rtl/wbh_reg_gen.sv
// Host-side configuration register bank: strap-adjusted skews, write lock,
// and per-channel software reset pulse generators.
module wbh_reg_gen #(
  parameter int          NUM_SKEW       = 8,
  parameter int          NUM_RST        = 4,
  parameter int          RST_PW_W       = 8,
  parameter logic [63:0] SKEW_RESET_VAL = 64'h0,
  parameter logic [15:0] GLB_RESET_VAL  = 16'h0003,
  parameter logic [15:0] BANK_RESET_VAL = 16'h1000,
  parameter logic [31:0] LOCK_KEY       = 32'hA5A5_5A5A
) (
  input  logic                  mclk,
  input  logic                  p_reset_n,
  input  logic                  s_reset_n,
  input  logic [31:0]           strap_sticky,
  input  logic [2*NUM_SKEW-1:0] strap_skew,
  input  logic                  soft_reboot,
  input  logic                  reg_cs,
  input  logic                  reg_wr,
  input  logic [2:0]            reg_addr,
  input  logic [31:0]           reg_wdata,
  input  logic [3:0]            reg_be,
  output logic [31:0]           reg_rdata,
  output logic                  reg_ack,
  output logic [15:0]           cfg_glb_ctrl,
  output logic [7:0]            cfg_clk_ctrl,
  output logic [15:0]           cfg_bank_sel,
  output logic [4*NUM_SKEW-1:0] cfg_clk_skew,
  output logic [NUM_RST-1:0]    soft_rst_n,
  output logic [31:0]           system_strap,
  output logic                  cfg_locked
);
  import wbh_reg_gen_pkg::*;

  logic                  init_done;
  logic [RST_PW_W-1:0]   rst_pw;
  logic                  access, wr_en, wr_ok;
  logic [63:0]           skew_ext;
  logic [31:0]           rd_mux, wr_merged;
  logic [4*NUM_SKEW-1:0] skew_init, skew_next;
  logic [NUM_RST-1:0]    trig, busy;

  assign access   = reg_cs & ~reg_ack & init_done;
  assign wr_en    = access & reg_wr;
  assign wr_ok    = wr_en & ~cfg_locked;
  assign skew_ext = 64'(cfg_clk_skew);

  // Read view of the addressed register; unimplemented bits read 0.
  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      REG_GLB:      rd_mux = {8'h0, cfg_clk_ctrl, cfg_glb_ctrl};
      REG_BANK:     rd_mux = {16'h0, cfg_bank_sel};
      REG_SKEW_LO:  rd_mux = skew_ext[31:0];
      REG_SKEW_HI:  rd_mux = skew_ext[63:32];
      REG_LOCK:     rd_mux = {31'h0, cfg_locked};
      REG_SOFT_RST: rd_mux = 32'(busy);
      REG_RST_PW:   rd_mux = 32'(rst_pw);
      default:      rd_mux = system_strap;
    endcase
    wr_merged = be_merge(rd_mux, reg_wdata, reg_be);
  end

  // Strap-adjusted init skews and byte-enabled skew write data.
  always_comb begin
    skew_init = '0;
    skew_next = cfg_clk_skew;
    for (int i = 0; i < NUM_SKEW; i++) begin
      skew_init[4*i +: 4] = SKEW_RESET_VAL[4*i +: 4] + skew_delta(strap_skew[2*i +: 2]);
      if (((reg_addr == REG_SKEW_HI) == (i >= 8)) && reg_be[(i % 8) / 2])
        skew_next[4*i +: 4] = reg_wdata[4*(i % 8) +: 4];
    end
  end

  // Soft-reset channel triggers ignore the lock.
  always_comb begin
    trig = '0;
    for (int i = 0; i < NUM_RST; i++)
      trig[i] = wr_en && (reg_addr == REG_SOFT_RST) && reg_wdata[i];
  end

  // Bus handshake: one-cycle ack, read data captured on the ack edge.
  always_ff @(posedge mclk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
    end else begin
      reg_ack <= access;
      if (access) reg_rdata <= rd_mux;
    end
  end

  // Configuration registers: init-cycle strap loads, then lock-gated writes.
  always_ff @(posedge mclk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      init_done    <= 1'b0;
      cfg_glb_ctrl <= GLB_RESET_VAL;
      cfg_clk_ctrl <= 8'h0;
      cfg_bank_sel <= BANK_RESET_VAL;
      cfg_clk_skew <= SKEW_RESET_VAL[4*NUM_SKEW-1:0];
      rst_pw       <= RST_PW_W'(RST_PW_DEFAULT);
      system_strap <= '0;
      cfg_locked   <= 1'b0;
    end else begin
      if (!init_done) begin
        init_done    <= 1'b1;
        cfg_clk_ctrl <= strap_sticky[7:0];
        cfg_clk_skew <= skew_init;
      end else if (wr_ok) begin
        case (reg_addr)
          REG_GLB: begin
            cfg_glb_ctrl <= wr_merged[15:0];
            cfg_clk_ctrl <= wr_merged[23:16];
          end
          REG_BANK:                 cfg_bank_sel <= wr_merged[15:0];
          REG_SKEW_LO, REG_SKEW_HI: cfg_clk_skew <= skew_next;
          REG_RST_PW:               rst_pw       <= wr_merged[RST_PW_W-1:0];
          default: ;
        endcase
      end
      // Soft reset and init reload the straps ahead of any bus write.
      if (!init_done || !s_reset_n)
        system_strap <= {soft_reboot, strap_sticky[30:0]};
      else if (wr_ok && reg_addr == REG_STRAP)
        system_strap <= wr_merged;
      if (wr_en && reg_addr == REG_LOCK)
        cfg_locked <= (reg_wdata != LOCK_KEY);
    end
  end

  // One pulse generator per software reset channel.
  for (genvar g = 0; g < NUM_RST; g++) begin : g_rst
    wbh_rst_pulse #(.PW_W(RST_PW_W)) u_pulse (
      .mclk      (mclk),
      .p_reset_n (p_reset_n),
      .trig      (trig[g]),
      .pw        (rst_pw),
      .rst_n     (soft_rst_n[g]),
      .busy      (busy[g])
    );
  end

endmodule

// File: tb/tb_wbh_reg_gen.sv
`timescale 1ns/1ps
module tb_wbh_reg_gen;
  localparam int          NUM_SKEW = 8;
  localparam int          NUM_RST  = 4;
  localparam int          RST_PW_W = 8;
  localparam logic [63:0] SKEW_RV  = 64'h23;
  localparam logic [15:0] GLB_RV   = 16'h0003;
  localparam logic [15:0] BANK_RV  = 16'h1000;
  localparam logic [31:0] KEY      = 32'hA5A5_5A5A;

  logic                  mclk = 1'b0;
  logic                  p_reset_n, s_reset_n, soft_reboot;
  logic [31:0]           strap_sticky;
  logic [2*NUM_SKEW-1:0] strap_skew;
  logic                  reg_cs, reg_wr, reg_ack, cfg_locked;
  logic [2:0]            reg_addr;
  logic [31:0]           reg_wdata, reg_rdata, system_strap;
  logic [3:0]            reg_be;
  logic [15:0]           cfg_glb_ctrl, cfg_bank_sel;
  logic [7:0]            cfg_clk_ctrl;
  logic [4*NUM_SKEW-1:0] cfg_clk_skew;
  logic [NUM_RST-1:0]    soft_rst_n;

  wbh_reg_gen #(
    .NUM_SKEW(NUM_SKEW), .NUM_RST(NUM_RST), .RST_PW_W(RST_PW_W),
    .SKEW_RESET_VAL(SKEW_RV), .GLB_RESET_VAL(GLB_RV),
    .BANK_RESET_VAL(BANK_RV), .LOCK_KEY(KEY)
  ) dut (
    .mclk(mclk), .p_reset_n(p_reset_n), .s_reset_n(s_reset_n),
    .strap_sticky(strap_sticky), .strap_skew(strap_skew), .soft_reboot(soft_reboot),
    .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_be(reg_be), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .cfg_glb_ctrl(cfg_glb_ctrl), .cfg_clk_ctrl(cfg_clk_ctrl), .cfg_bank_sel(cfg_bank_sel),
    .cfg_clk_skew(cfg_clk_skew), .soft_rst_n(soft_rst_n), .system_strap(system_strap),
    .cfg_locked(cfg_locked)
  );

  always #5 mclk = ~mclk;

  int total = 0;
  int passed = 0;

  // Reference model: register words as seen on a read, lock flag,
  // and remaining low cycles per reset channel.
  logic [31:0] mreg[8];
  logic [31:0] mreg_pre[8];
  logic [31:0] busy_pre;
  bit          mlocked;
  bit          srst_edge;
  int          rem[NUM_RST];
  int          low0, low1;

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int sdelta(input int code);
    case (code)
      0: return 0;
      1: return 2;
      2: return 4;
      default: return -4;
    endcase
  endfunction

  function automatic logic [31:0] impl_mask(input logic [2:0] a);
    case (a)
      3'd0: return 32'h00FF_FFFF;
      3'd1: return 32'h0000_FFFF;
      3'd2: return 32'hFFFF_FFFF;
      3'd6: return 32'h0000_00FF;
      3'd7: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_init();
    logic [63:0] base;
    base = SKEW_RV;
    mreg[0] = {8'h0, strap_sticky[7:0], GLB_RV};
    mreg[1] = {16'h0, BANK_RV};
    mreg[2] = '0;
    mreg[3] = '0;
    for (int i = 0; i < NUM_SKEW; i++) begin
      int v;
      v = int'(base[4*i +: 4]) + sdelta(int'(strap_skew[2*i +: 2]));
      v = ((v % 16) + 16) % 16;
      mreg[i / 8][4*(i % 8) +: 4] = 4'(v);
    end
    mreg[4] = '0;
    mreg[5] = '0;
    mreg[6] = 32'd16;
    mreg[7] = {soft_reboot, strap_sticky[30:0]};
    mlocked = 1'b0;
    for (int i = 0; i < NUM_RST; i++) rem[i] = 0;
  endtask

  // Advance one edge and sample 1 ns later; the model ages the pulses.
  task automatic tick();
    mreg_pre = mreg;
    busy_pre = '0;
    for (int i = 0; i < NUM_RST; i++) busy_pre[i] = (rem[i] > 0);
    srst_edge = !s_reset_n;
    @(posedge mclk);
    #1;
    for (int i = 0; i < NUM_RST; i++) if (rem[i] > 0) rem[i]--;
    if (srst_edge) mreg[7] = {soft_reboot, strap_sticky[30:0]};
  endtask

  task automatic chk_rst();
    logic [NUM_RST-1:0] e;
    for (int i = 0; i < NUM_RST; i++) e[i] = (rem[i] == 0);
    check("soft_rst_n", 64'(soft_rst_n), 64'(e));
    if (!soft_rst_n[0]) low0++;
    if (!soft_rst_n[1]) low1++;
  endtask

  task automatic step();
    tick();
    chk_rst();
  endtask

  task automatic bus(input bit wr, input logic [2:0] a, input logic [31:0] d,
                     input logic [3:0] be, output logic [31:0] rd, output logic [31:0] ex);
    int lat_exp, n;
    logic [31:0] bm, im;
    lat_exp = reg_ack ? 2 : 1;
    reg_cs = 1'b1; reg_wr = wr; reg_addr = a; reg_wdata = d; reg_be = be;
    ex = '0;
    tick();
    n = 1;
    while (!reg_ack && n < 6) begin
      chk_rst();
      tick();
      n++;
    end
    check("ack_latency", 64'(n), 64'(lat_exp));
    if (reg_ack) begin
      if (a == 3'd4)      ex = {31'h0, mlocked};
      else if (a == 3'd5) ex = busy_pre;
      else                ex = mreg_pre[a];
      if (wr) begin
        bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        im = impl_mask(a);
        if (a == 3'd4) mlocked = (d != KEY);
        else if (a == 3'd5) begin
          for (int i = 0; i < NUM_RST; i++)
            if (d[i]) rem[i] = (mreg[6] == 0) ? 1 : int'(mreg[6]);
        end else if (!mlocked && !(a == 3'd7 && srst_edge))
          mreg[a] = (mreg[a] & ~(bm & im)) | (d & bm & im);
      end
    end
    chk_rst();
    rd = reg_rdata;
    reg_cs = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, ex;
    logic [63:0] skew_base;
    vec_t        tbl[$];

    skew_base = SKEW_RV;
    p_reset_n = 1'b0; s_reset_n = 1'b1; soft_reboot = 1'b0;
    strap_sticky = 32'hC0DE_005A;
    strap_skew   = 16'h000D;          // field0 = 01, field1 = 11, rest 00
    reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = 3'd0; reg_wdata = '0; reg_be = '0;
    for (int i = 0; i < NUM_RST; i++) rem[i] = 0;
    low0 = 0; low1 = 0;
    #12;
    check("rst_rdata", 64'(reg_rdata), 64'h0);
    check("rst_ack", 64'(reg_ack), 64'h0);
    check("rst_glb", 64'(cfg_glb_ctrl), 64'h0003);
    check("rst_clk", 64'(cfg_clk_ctrl), 64'h0);
    check("rst_bank", 64'(cfg_bank_sel), 64'h1000);
    check("rst_skew", 64'(cfg_clk_skew), 64'(skew_base[31:0]));
    check("rst_softrst", 64'(soft_rst_n), 64'hF);
    check("rst_strap", 64'(system_strap), 64'h0);
    check("rst_locked", 64'(cfg_locked), 64'h0);

    // Release with cs already held: init edge, then the first access.
    p_reset_n = 1'b1;
    tick();
    check("init_ack_low", 64'(reg_ack), 64'h0);
    check("init_clk", 64'(cfg_clk_ctrl), 64'h5A);
    check("init_skew", 64'(cfg_clk_skew), 64'h0000_00E5);
    check("init_strap", 64'(system_strap), 64'h40DE_005A);
    tick();
    check("first_ack", 64'(reg_ack), 64'h1);
    check("first_rdata", 64'(reg_rdata), 64'h005A_0003);
    reg_cs = 1'b0;
    model_init();
    step();
    check("ack_clear", 64'(reg_ack), 64'h0);

    // Directed register vectors: writes, then reads with expected data.
    tbl.push_back('{1'b0, 3'd0, 32'h0, 4'h0, 32'h005A_0003});
    tbl.push_back('{1'b0, 3'd1, 32'h0, 4'h0, 32'h0000_1000});
    tbl.push_back('{1'b0, 3'd2, 32'h0, 4'h0, 32'h0000_00E5});
    tbl.push_back('{1'b0, 3'd3, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 3'd4, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 3'd6, 32'h0, 4'h0, 32'h10});
    tbl.push_back('{1'b0, 3'd7, 32'h0, 4'h0, 32'h40DE_005A});
    tbl.push_back('{1'b1, 3'd0, 32'h00FF_1234, 4'b0101, 32'h0});
    tbl.push_back('{1'b0, 3'd0, 32'h0, 4'h0, 32'h00FF_0034});
    tbl.push_back('{1'b1, 3'd4, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 3'd4, 32'h0, 4'h0, 32'h1});
    tbl.push_back('{1'b1, 3'd1, 32'h0000_BEEF, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 3'd1, 32'h0, 4'h0, 32'h0000_1000});
    tbl.push_back('{1'b1, 3'd4, KEY, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 3'd4, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b1, 3'd1, 32'h0000_BEEF, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 3'd1, 32'h0, 4'h0, 32'h0000_BEEF});
    tbl.push_back('{1'b1, 3'd3, 32'hFFFF_FFFF, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 3'd3, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b1, 3'd2, 32'h1234_5678, 4'b1100, 32'h0});
    tbl.push_back('{1'b0, 3'd2, 32'h0, 4'h0, 32'h1234_00E5});
    tbl.push_back('{1'b1, 3'd6, 32'hFFFF_FF03, 4'b0001, 32'h0});
    tbl.push_back('{1'b0, 3'd6, 32'h0, 4'h0, 32'h3});
    tbl.push_back('{1'b1, 3'd7, 32'hDEAD_BEEF, 4'b1000, 32'h0});
    tbl.push_back('{1'b0, 3'd7, 32'h0, 4'h0, 32'hDEDE_005A});
    tbl.push_back('{1'b1, 3'd0, 32'hFFFF_FFFF, 4'b1000, 32'h0});
    tbl.push_back('{1'b0, 3'd0, 32'h0, 4'h0, 32'h00FF_0034});
    foreach (tbl[k]) begin
      bus(tbl[k].wr, tbl[k].addr, tbl[k].wdata, tbl[k].be, rd, ex);
      if (!tbl[k].wr) check($sformatf("vec%0d_rd", k), 64'(rd), 64'(tbl[k].exp));
    end
    check("vec_glb", 64'(cfg_glb_ctrl), 64'h0034);
    check("vec_clk", 64'(cfg_clk_ctrl), 64'hFF);
    check("vec_bank", 64'(cfg_bank_sel), 64'hBEEF);
    check("vec_skew", 64'(cfg_clk_skew), 64'h1234_00E5);
    check("vec_strap", 64'(system_strap), 64'hDEDE_005A);

    // Pulse of width 3 with busy readback in the middle.
    bus(1'b1, 3'd6, 32'h3, 4'h1, rd, ex);
    low1 = 0;
    bus(1'b1, 3'd5, 32'h2, 4'hF, rd, ex);
    bus(1'b0, 3'd5, 32'h0, 4'h0, rd, ex);
    check("busy_rd", 64'(rd), 64'h2);
    repeat (6) step();
    check("pulse3_len", 64'(low1), 64'd3);

    // Re-trigger two cycles in extends the pulse to 5 cycles.
    low1 = 0;
    bus(1'b1, 3'd5, 32'h2, 4'hF, rd, ex);
    bus(1'b1, 3'd5, 32'h2, 4'hF, rd, ex);
    repeat (8) step();
    check("retrig_len", 64'(low1), 64'd5);

    // Width 0 gives a single-cycle pulse.
    bus(1'b1, 3'd6, 32'h0, 4'h1, rd, ex);
    low0 = 0;
    bus(1'b1, 3'd5, 32'h1, 4'hF, rd, ex);
    repeat (4) step();
    check("pw0_len", 64'(low0), 64'd1);

    // Soft reset beats a same-cycle strap write.
    s_reset_n = 1'b0; strap_sticky = 32'h1234_ABCD; soft_reboot = 1'b1;
    bus(1'b1, 3'd7, 32'h1111_1111, 4'hF, rd, ex);
    s_reset_n = 1'b1;
    step();
    check("srst_strap", 64'(system_strap), 64'h9234_ABCD);
    bus(1'b0, 3'd7, 32'h0, 4'h0, rd, ex);
    check("srst_strap_rd", 64'(rd), 64'h9234_ABCD);

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      bit w;
      logic [2:0] a;
      logic [31:0] d;
      logic [3:0] be;
      w  = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      d  = $urandom();
      be = 4'($urandom_range(0, 15));
      if (a == 3'd4 && $urandom_range(0, 1) == 1) d = KEY;
      if (a == 3'd6) d[7:0] = 8'($urandom_range(0, 6));
      bus(w, a, d, be, rd, ex);
      if (!w) check($sformatf("rand%0d_rd_a%0d", k, a), 64'(rd), 64'(ex));
      if ($urandom_range(0, 3) == 0) step();
    end
    check("rand_glb", 64'(cfg_glb_ctrl), 64'(mreg[0][15:0]));
    check("rand_clk", 64'(cfg_clk_ctrl), 64'(mreg[0][23:16]));
    check("rand_bank", 64'(cfg_bank_sel), 64'(mreg[1][15:0]));
    check("rand_skew", 64'(cfg_clk_skew), 64'(mreg[2]));
    check("rand_strap", 64'(system_strap), 64'(mreg[7]));
    check("rand_locked", 64'(cfg_locked), 64'(mlocked));

    // Async reset in the middle of a long pulse while ack is high.
    bus(1'b1, 3'd4, KEY, 4'h0, rd, ex);
    bus(1'b1, 3'd6, 32'd20, 4'h1, rd, ex);
    bus(1'b1, 3'd5, 32'hF, 4'hF, rd, ex);
    check("pre_areset_low", 64'(soft_rst_n), 64'h0);
    #1 p_reset_n = 1'b0;
    #1;
    check("areset_softrst", 64'(soft_rst_n), 64'hF);
    check("areset_ack", 64'(reg_ack), 64'h0);
    check("areset_skew", 64'(cfg_clk_skew), 64'(skew_base[31:0]));
    #2 p_reset_n = 1'b1;
    model_init();
    step();
    check("reinit_clk", 64'(cfg_clk_ctrl), 64'hCD);
    check("reinit_ack", 64'(reg_ack), 64'h0);
    bus(1'b0, 3'd0, 32'h0, 4'h0, rd, ex);
    check("reinit_rd0", 64'(rd), 64'h00CD_0003);
    bus(1'b0, 3'd7, 32'h0, 4'h0, rd, ex);
    check("reinit_rd7", 64'(rd), 64'(ex));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wbh_reg_gen.md
Name: wbh_reg_gen

Overview:
Parametrised host-side configuration register bank for the wishbone host. It is the successor of the fixed global/clock/bank/skew/strap register set. It adds:
- N-field strap-adjusted clock-skew registers, loaded by a post-reset init cycle.
- A key-based write lock.
- Per-channel software reset pulse generators with programmable width.
Sits between the wb_host reg bus decoder and the clock/reset distribution logic.

Parameters:
NUM_SKEW, 8, number of 4-bit skew fields (1..16); fields 0-7 in reg 2, 8-15 in reg 3
NUM_RST, 4, number of software reset pulse channels (1..16)
RST_PW_W, 8, pulse-width counter width (2..16)
SKEW_RESET_VAL, 64'h0, base skew values, 4 bits per field
GLB_RESET_VAL, 16'h0003, cfg_glb_ctrl reset value
BANK_RESET_VAL, 16'h1000, cfg_bank_sel reset value
LOCK_KEY, 32'hA5A5_5A5A, unlock key

Ports:
mclk  in  1  register clock
p_reset_n  in  1  asynchronous active-low reset; all flops
s_reset_n  in  1  synchronous active-low soft reset, reloads system_strap only
strap_sticky  in  32  latched straps; [7:0] = clk_ctrl default
strap_skew  in  2*NUM_SKEW  per-field skew strap codes
soft_reboot  in  1  loaded into system_strap[31]
reg_cs, reg_wr  in  1 each  bus request
reg_addr  in  3  word address
reg_wdata  in  32  write data
reg_be  in  4  byte enables
reg_rdata  out  32  read data, registered
reg_ack  out  1  single-cycle ack
cfg_glb_ctrl  out  16  reg0[15:0]
cfg_clk_ctrl  out  8  reg0[23:16]
cfg_bank_sel  out  16  reg1[15:0]
cfg_clk_skew  out  4*NUM_SKEW  packed skew fields
soft_rst_n  out  NUM_RST  active-low reset pulses
system_strap  out  32  reg7
cfg_locked  out  1  write-lock status

Behaviour:
- Reset values (async):
  - reg_rdata=0, reg_ack=0
  - cfg_glb_ctrl=GLB_RESET_VAL, cfg_clk_ctrl=0, cfg_bank_sel=BANK_RESET_VAL
  - cfg_clk_skew=SKEW_RESET_VAL (unadjusted), soft_rst_n=all 1
  - system_strap=0, cfg_locked=0, pulse width=16, init_done=0
- Init cycle: first mclk edge with init_done=0 does the following, then sets init_done=1:
  - cfg_clk_ctrl <= strap_sticky[7:0]
  - skew field i <= SKEW_RESET_VAL[4i+:4] + {0,+2,+4,-4}[strap_skew[2i+:2]], modulo 16
  - system_strap <= {soft_reboot, strap_sticky[30:0]}
  - reg_ack is held 0 during this cycle.
- Bus handshake:
  - When cs=1, ack=0 and init_done=1, the next edge sets ack=1; the following edge clears it.
  - The master holds cs until ack. A continuously held cs gives one access every 2 cycles.
  - A write commits on the same edge that sets ack. Read data is registered on that edge.
- Byte enables: reg_be applies to regs 0,1,2,3,6,7. Regs 4 and 5 ignore reg_be.
- Register map:
  - 0: {8'h0, clk_ctrl, glb_ctrl}
  - 1: {16'h0, bank_sel}
  - 2: skew fields 0-7
  - 3: skew fields 8-15
  - 4: LOCK; read {31'h0, cfg_locked}
  - 5: SOFT_RST; write 1 to bit i to trigger channel i; read = busy bits
  - 6: RST_PW[RST_PW_W-1:0]
  - 7: system_strap
  - Unimplemented bits and fields read 0; writes to them are dropped.
- Lock:
  - Writing LOCK_KEY to reg 4 clears cfg_locked; writing any other value sets it.
  - While locked, writes to regs 0-3, 6 and 7 are ignored but still acked. Regs 4 and 5 stay writable.
- s_reset_n=0 (sampled synchronously): system_strap <= {soft_reboot, strap_sticky[30:0]}. This has priority over a reg-7 write in the same cycle.
- Reset pulse channel FSM (per channel):
  - IDLE: soft_rst_n[i]=1. On trigger, load count with max(RST_PW,1) and go to ACTIVE.
  - ACTIVE: soft_rst_n[i]=0, count decrements each cycle; move to IDLE on the edge where count==1.
  - Low pulse lasts exactly max(RST_PW,1) cycles, starting the cycle after the write edge.
  - A re-trigger while ACTIVE reloads the count (extends the pulse). A trigger with bit=0 has no effect.
  - Changing RST_PW while ACTIVE does not affect the running count.
- p_reset_n assertion mid-pulse forces soft_rst_n high immediately (async).

Decomposition:
- Package wbh_reg_gen_pkg holds:
  - register address constants (REG_GLB..REG_STRAP)
  - skew strap delta function/lookup
  - reset pulse state enum {RP_IDLE, RP_ACTIVE}
- Sub-module wbh_rst_pulse (one per channel, generate loop), ports:
  - inputs: mclk, p_reset_n, trig, pw
  - outputs: rst_n, busy

Test Plan:
- Reset release with strap_skew field0=2'b01, SKEW_RESET_VAL field0=4'h3, strap_sticky[7:0]=8'h5A -> after init cycle cfg_clk_skew[3:0]=4'h5, cfg_clk_ctrl=8'h5A; a cs held from reset gets ack no earlier than the 2nd edge.
- Field code 2'b11 on base 4'h2 -> 4'hE (wrap). Read reg 3 with NUM_SKEW=8 -> 32'h0.
- Write reg0 32'h00FF_1234 with be=4'b0101 -> cfg_glb_ctrl=16'h0034 (upper byte keeps reset 8'h00), cfg_clk_ctrl=8'hFF.
- Write reg4 = 0 -> cfg_locked=1. Write reg1 = 16'hBEEF -> acked, bank_sel stays 16'h1000. Write reg4 = LOCK_KEY -> unlocked; the reg1 write now takes effect.
- RST_PW=3, write reg5 = 4'b0010 -> soft_rst_n[1] low for exactly 3 cycles, reg5 reads 32'h2 meanwhile. Re-trigger at cycle 2 -> low for 5 cycles total. RST_PW=0 -> 1-cycle pulse.
- Write reg7 while s_reset_n=0 -> system_strap = {soft_reboot, strap_sticky[30:0]}. Assert p_reset_n mid-pulse -> soft_rst_n all 1 and reg_ack 0 immediately.
